// File: rtl/add_sub_bist.sv
// Built-in self-test controller for the 4-bit add_sub unit: sweeps all {a,b,cin} vectors and checks them against a golden model.
// Optional macro ADD_SUB_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module add_sub_bist #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic             cin_o,
   input  logic [WIDTH-1:0] sum_i,
   input  logic             cout_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic             fail_cin
);

   localparam int               IDX_W     = 2 * WIDTH + 1;
   localparam logic [IDX_W-1:0] IDX_LAST  = {IDX_W{1'b1}};
   localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [3:0]       SETTLE_M1 = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Subtract is a + ~b + 1, so cout=1 means no borrow.
   function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
      logic [WIDTH:0] r;
      if (cin) begin
         r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      end else begin
         r = {1'b0, a} + {1'b0, b};
      end
      return r;
   endfunction

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [3:0]       settle_q;
   logic [WIDTH-1:0] a_q, b_q, fail_a_q, fail_b_q;
   logic             cin_q, fail_cin_q, fail_valid_q;
   logic             busy_q, done_q, pass_q;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             mismatch_s, stop_s;

   // Response compare and saturating error-count increment.
   always_comb begin
      mismatch_s = ({cout_i, sum_i} != golden(a_q, b_q, cin_q));
      if (err_cnt_q == {ERR_W{1'b1}}) begin
         err_cnt_d = err_cnt_q;
      end else begin
         err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end
   end

`ifdef ADD_SUB_BIST_STOP_ON_FAIL_EN
   assign stop_s = mismatch_s;
`else
   assign stop_s = 1'b0;
`endif

   // Sweep FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= {IDX_W{1'b0}};
         settle_q     <= 4'd0;
         a_q          <= {WIDTH{1'b0}};
         b_q          <= {WIDTH{1'b0}};
         cin_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= {ERR_W{1'b0}};
         fail_valid_q <= 1'b0;
         fail_a_q     <= {WIDTH{1'b0}};
         fail_b_q     <= {WIDTH{1'b0}};
         fail_cin_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q      <= ST_DRIVE;
                  idx_q        <= {IDX_W{1'b0}};
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  err_cnt_q    <= {ERR_W{1'b0}};
                  fail_valid_q <= 1'b0;
                  fail_a_q     <= {WIDTH{1'b0}};
                  fail_b_q     <= {WIDTH{1'b0}};
                  fail_cin_q   <= 1'b0;
               end
            end
            ST_DRIVE: begin
               {a_q, b_q, cin_q} <= idx_q;
               settle_q          <= 4'd0;
               if (SETTLE == 0) begin
                  state_q <= ST_CHECK;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (settle_q == SETTLE_M1) begin
                  state_q <= ST_CHECK;
               end else begin
                  settle_q <= settle_q + 4'd1;
               end
            end
            ST_CHECK: begin
               if (mismatch_s) begin
                  err_cnt_q <= err_cnt_d;
                  if (!fail_valid_q) begin
                     fail_valid_q <= 1'b1;
                     fail_a_q     <= a_q;
                     fail_b_q     <= b_q;
                     fail_cin_q   <= cin_q;
                  end
               end
               if ((idx_q == IDX_LAST) || stop_s) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= !mismatch_s && (err_cnt_q == {ERR_W{1'b0}});
               end else begin
                  state_q <= ST_DRIVE;
                  idx_q   <= idx_q + IDX_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
            end
         endcase
      end
   end

   assign a_o        = a_q;
   assign b_o        = b_q;
   assign cin_o      = cin_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_cnt_q;
   assign fail_valid = fail_valid_q;
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;
   assign fail_cin   = fail_cin_q;

endmodule

// File: tb/tb_add_sub_bist.sv
// Directed testbench for add_sub_bist: an add_sub model with injectable faults, plus a SETTLE=0 instance.
module tb_add_sub_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, cin_o, cout_i, busy, done, pass, fail_valid, fail_cin;
   logic [3:0]  a_o, b_o, sum_i, fail_a, fail_b;
   logic [15:0] err_cnt;
   logic        rst0, start0, cin_o0, cout_i0, busy0, done0, pass0, fail_valid0, fail_cin0;
   logic [3:0]  a_o0, b_o0, sum_i0, fail_a0, fail_b0;
   logic [15:0] err_cnt0;
   logic [4:0]  r_s, r0_s;
   int          fault_mode;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [4:0] add_sub_model(input logic [3:0] a, input logic [3:0] b, input logic cin);
      logic [4:0] bx;
      bx = cin ? {1'b0, ~b} : {1'b0, b};
      return {1'b0, a} + bx + {4'd0, cin};
   endfunction

   // add_sub unit attached to each controller; fault_mode 1 ties sum[0] low, 2 ties cout low.
   always_comb begin
      r_s    = add_sub_model(a_o, b_o, cin_o);
      sum_i  = r_s[3:0];
      cout_i = r_s[4];
      if (fault_mode == 1) sum_i[0] = 1'b0;
      if (fault_mode == 2) cout_i = 1'b0;
      r0_s    = add_sub_model(a_o0, b_o0, cin_o0);
      sum_i0  = r0_s[3:0];
      cout_i0 = r0_s[4];
   end

   add_sub_bist #(.WIDTH(4), .SETTLE(1), .ERR_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a_o(a_o), .b_o(b_o), .cin_o(cin_o),
      .sum_i(sum_i), .cout_i(cout_i), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
      .fail_cin(fail_cin));

   add_sub_bist #(.WIDTH(4), .SETTLE(0), .ERR_W(16)) u_dut0 (
      .clk(clk), .rst(rst0), .start(start0), .a_o(a_o0), .b_o(b_o0), .cin_o(cin_o0),
      .sum_i(sum_i0), .cout_i(cout_i0), .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err_cnt0), .fail_valid(fail_valid0), .fail_a(fail_a0), .fail_b(fail_b0),
      .fail_cin(fail_cin0));

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      fault_mode = 0;
      rst = 1'b1; start = 1'b0; rst0 = 1'b1; start0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({a_o, b_o, cin_o, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b, fail_cin} !== 45'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", {a_o, b_o, cin_o, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b, fail_cin});
      end
      @(negedge clk);
      rst = 1'b0; rst0 = 1'b0;
   endtask

   task automatic test_full_pass();
      int cyc;
      fault_mode = 0;
      pulse_start();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t1_busy got busy=%b done=%b want 1 0", busy, done); end
      wait_done(cyc);
      checks++;
      if (cyc != 1536) begin errors++; $display("FAIL t1_cycles got %0d want 1536", cyc); end
      checks++;
      if (pass !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t1_pass got pass=%b busy=%b want 1 0", pass, busy); end
      checks++;
      if (err_cnt !== 16'd0 || fail_valid !== 1'b0) begin errors++; $display("FAIL t1_err got %0d/%b want 0/0", err_cnt, fail_valid); end
      checks++;
      if ({a_o, b_o, cin_o} !== 9'h1FF) begin errors++; $display("FAIL t1_last_vec got %h want 1ff", {a_o, b_o, cin_o}); end
   endtask

   task automatic test_sum0_fault();
      int cyc;
      fault_mode = 1;
      pulse_start();
      wait_done(cyc);
`ifdef ADD_SUB_BIST_STOP_ON_FAIL_EN
      checks++;
      if (cyc != 9) begin errors++; $display("FAIL t4_cycles got %0d want 9", cyc); end
      checks++;
      if (err_cnt !== 16'd1) begin errors++; $display("FAIL t4_err_cnt got %0d want 1", err_cnt); end
      checks++;
      if ({a_o, b_o, cin_o} !== {4'd0, 4'd1, 1'b0}) begin errors++; $display("FAIL t4_hold_vec got %h want 002", {a_o, b_o, cin_o}); end
`else
      checks++;
      if (cyc != 1536) begin errors++; $display("FAIL t2_cycles got %0d want 1536", cyc); end
      checks++;
      if (err_cnt !== 16'd256) begin errors++; $display("FAIL t2_err_cnt got %0d want 256", err_cnt); end
`endif
      checks++;
      if ({fail_valid, fail_a, fail_b, fail_cin} !== {1'b1, 4'd0, 4'd1, 1'b0}) begin
         errors++; $display("FAIL t2_fail_vec got %h want 202", {fail_valid, fail_a, fail_b, fail_cin});
      end
      checks++;
      if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL t2_pass got pass=%b done=%b want 0 1", pass, done); end
   endtask

   task automatic test_cout_fault();
      int cyc;
      fault_mode = 2;
      pulse_start();
      wait_done(cyc);
`ifdef ADD_SUB_BIST_STOP_ON_FAIL_EN
      checks++;
      if (cyc != 6 || err_cnt !== 16'd1) begin errors++; $display("FAIL t3_stop got cyc=%0d err=%0d want 6 1", cyc, err_cnt); end
`else
      checks++;
      if (cyc != 1536 || err_cnt !== 16'd256) begin errors++; $display("FAIL t3_err_cnt got cyc=%0d err=%0d want 1536 256", cyc, err_cnt); end
`endif
      checks++;
      if ({fail_valid, fail_a, fail_b, fail_cin} !== {1'b1, 4'd0, 4'd0, 1'b1}) begin
         errors++; $display("FAIL t3_fail_vec got %h want 201", {fail_valid, fail_a, fail_b, fail_cin});
      end
   endtask

   task automatic test_rst_mid_and_ignored_start();
      int cyc;
      fault_mode = 1;
      pulse_start();
      repeat (99) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({a_o, b_o, cin_o, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b, fail_cin} !== 45'd0) begin
         errors++;
         $display("FAIL t5_rst_outputs got %h want 0", {a_o, b_o, cin_o, busy, done, pass, err_cnt, fail_valid, fail_a, fail_b, fail_cin});
      end
      rst = 1'b0;
      fault_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL t5_idle got busy=%b done=%b want 0 0", busy, done); end
      pulse_start();
      cyc = 0;
      while (!done && cyc < 3000) begin
         start = (cyc == 10 || cyc == 50 || cyc == 700);
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (cyc != 1536) begin errors++; $display("FAIL t5_cycles got %0d want 1536", cyc); end
      checks++;
      if (pass !== 1'b1 || err_cnt !== 16'd0) begin errors++; $display("FAIL t5_pass got pass=%b err=%0d want 1 0", pass, err_cnt); end
   endtask

   task automatic test_settle0();
      int cyc;
      for (int run = 0; run < 2; run++) begin
         @(negedge clk);
         start0 = 1'b1;
         @(posedge clk);
         #1;
         start0 = 1'b0;
         checks++;
         if (done0 !== 1'b0 || pass0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++; $display("FAIL t6_start%0d got done=%b pass=%b busy=%b want 0 0 1", run, done0, pass0, busy0);
         end
         cyc = 0;
         while (!done0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         checks++;
         if (cyc != 1024) begin errors++; $display("FAIL t6_cycles%0d got %0d want 1024", run, cyc); end
         checks++;
         if (pass0 !== 1'b1 || err_cnt0 !== 16'd0 || fail_valid0 !== 1'b0) begin
            errors++; $display("FAIL t6_pass%0d got pass=%b err=%0d fv=%b want 1 0 0", run, pass0, err_cnt0, fail_valid0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_sum0_fault();
      test_cout_fault();
      test_rst_mid_and_ignored_start();
      test_settle0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
